// File: rtl/codeword_tx.sv
// codeword_tx - serial codeword transmitter.
//
// Accepts parallel WIDTH-bit words over a valid/ready handshake and shifts
// them out one bit per enabled clock, LSB first, onto ser_out (drives the
// sequence detector's `msb` input). An accept during the last bit of a word
// chains the next word with no gap.
//
// Build option: define CODEWORD_TX_FILL_EN to drive a 16-bit LFSR pattern
// (x^16+x^14+x^13+x^11+1) on the line while idle; otherwise idle bits are 0.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   LFSR_SEED  reset value of the filler LFSR (nonzero)
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sh_en        shift enable; 0 freezes all state
//   in_valid     in_data holds a word to send
//   in_data      word to send; bit 0 goes first
//   in_ready     word is accepted at this rising edge if in_valid
//   ser_out      registered serial bit
//   frame_start  ser_out carries bit 0 of a word
//   frame_last   ser_out carries bit WIDTH-1 of a word
//   busy         a word is on the line
//   words_sent   count of accepted words (wraps at 2^32)
module codeword_tx #(
    parameter int          WIDTH     = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sh_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy,
    output logic [31:0]      words_sent
);

    localparam int            IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("codeword_tx: WIDTH must be in 2..32");
        end
        if (LFSR_SEED == 16'h0000) begin : g_bad_seed
            $error("codeword_tx: LFSR_SEED must be nonzero");
        end
    endgenerate

    logic [0:0]       state;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             idle_bit;

    // Ready in IDLE or on the last bit, so a new word can follow gap-free.
    assign in_ready    = sh_en && (state == ST_IDLE || bit_idx == LAST);
    assign accept      = in_valid && in_ready;

    assign busy        = (state == ST_SHIFT);
    assign frame_start = (state == ST_SHIFT) && (bit_idx == '0);
    assign frame_last  = (state == ST_SHIFT) && (bit_idx == LAST);

`ifdef CODEWORD_TX_FILL_EN
    logic [15:0] lfsr;

    // Advances only on the edges that actually put a filler bit on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (sh_en && !accept && (state == ST_IDLE ||
                                          bit_idx == LAST)) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign idle_bit = lfsr[0];
`else
    assign idle_bit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            ser_out    <= 1'b0;
            words_sent <= '0;
        end else if (sh_en) begin
            if (accept) begin
                shreg      <= in_data;
                ser_out    <= in_data[0];
                bit_idx    <= '0;
                state      <= ST_SHIFT;
                words_sent <= words_sent + 32'd1;
            end else if (state == ST_SHIFT && bit_idx != LAST) begin
                ser_out <= shreg[bit_idx + 1'b1];
                bit_idx <= bit_idx + 1'b1;
            end else begin
                // End of word without a follow-on, or idle: drive the idle bit.
                state   <= ST_IDLE;
                ser_out <= idle_bit;
            end
        end
    end

endmodule

// File: tb/tb_codeword_tx.sv
// tb_codeword_tx - directed, table-driven bench for codeword_tx (WIDTH=5).
// Works in both builds; idle bits are predicted by a reference LFSR model
// when CODEWORD_TX_FILL_EN is defined and are 0 otherwise.
module tb_codeword_tx;

    localparam int W = 5;

    // Expected ser_out codes.
    localparam logic [1:0] S0 = 2'd0;   // literal 0
    localparam logic [1:0] S1 = 2'd1;   // literal 1
    localparam logic [1:0] SI = 2'd2;   // idle bit (from LFSR model)
    localparam logic [1:0] SH = 2'd3;   // held previous value

    typedef struct {
        logic         en;
        logic         vld;
        logic [W-1:0] d;
        logic         rdy;
        logic [1:0]   ser;
        logic         fs;
        logic         fl;
        logic         busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sh_en;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         ser_out;
    logic         frame_start;
    logic         frame_last;
    logic         busy;
    logic [31:0]  words_sent;

    codeword_tx #(.WIDTH(W), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sh_en      (sh_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .frame_start(frame_start),
        .frame_last (frame_last),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned n_acc  = 0;
    logic [15:0] ref_lfsr = 16'hACE1;
    logic        last_ser = 1'b0;

    function automatic vec_t V(input logic en, input logic vld,
                               input logic [W-1:0] d, input logic rdy,
                               input logic [1:0] ser, input logic fs,
                               input logic fl, input logic bsy);
        vec_t v;
        v.en = en; v.vld = vld; v.d = d; v.rdy = rdy;
        v.ser = ser; v.fs = fs; v.fl = fl; v.busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // x^16+x^14+x^13+x^11+1, shift right, feedback into bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic next_idle_bit();
        logic b;
`ifdef CODEWORD_TX_FILL_EN
        b = ref_lfsr[0];
        ref_lfsr = lfsr_step(ref_lfsr);
`else
        b = 1'b0;
`endif
        return b;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic exp_ser;
        @(negedge clk);
        sh_en    = v.en;
        in_valid = v.vld;
        in_data  = v.d;
        #1;
        chk({name, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
        if (v.vld && v.rdy) n_acc++;
        @(posedge clk);
        #1;
        case (v.ser)
            S0:      exp_ser = 1'b0;
            S1:      exp_ser = 1'b1;
            SI:      exp_ser = next_idle_bit();
            default: exp_ser = last_ser;
        endcase
        last_ser = exp_ser;
        n_vec++;
        chk({name, ".ser_out"},     32'(ser_out),     32'(exp_ser));
        chk({name, ".frame_start"}, 32'(frame_start), 32'(v.fs));
        chk({name, ".frame_last"},  32'(frame_last),  32'(v.fl));
        chk({name, ".busy"},        32'(busy),        32'(v.busy));
    endtask

    task automatic run(input vec_t q[$], input string name);
        foreach (q[i]) apply(q[i], $sformatf("%s[%0d]", name, i));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ".ser_out"},     32'(ser_out),     32'd0);
        chk({name, ".frame_start"}, 32'(frame_start), 32'd0);
        chk({name, ".frame_last"},  32'(frame_last),  32'd0);
        chk({name, ".busy"},        32'(busy),        32'd0);
        chk({name, ".words_sent"},  words_sent,       32'd0);
        chk({name, ".in_ready"},    32'(in_ready),    32'(sh_en));
    endtask

    // Release on a falling edge with sh_en=0 so no unmodelled edge occurs.
    task automatic release_reset();
        @(negedge clk);
        sh_en    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        ref_lfsr = 16'hACE1;
        last_ser = 1'b0;
        n_acc    = 0;
        #1;
    endtask

    vec_t t_one[$], t_b2b[$], t_stall[$], t_pre_rst[$], t_post_rst[$];
    vec_t q[$];

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] rx;
        int unsigned  hits_tx, hits_rx;

        // Single 10001 word, then idle.
        t_one = '{
            V(1,1,5'h11,1,S1,1,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(1,0,5'h00,0,S0,0,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(1,0,5'h00,0,S1,0,1,1), V(1,0,5'h00,1,SI,0,0,0)
        };
        // 10001, 01110, 11111 back-to-back with in_valid held.
        t_b2b = '{
            V(1,1,5'h11,1,S1,1,0,1), V(1,1,5'h0E,0,S0,0,0,1),
            V(1,1,5'h0E,0,S0,0,0,1), V(1,1,5'h0E,0,S0,0,0,1),
            V(1,1,5'h0E,0,S1,0,1,1), V(1,1,5'h0E,1,S0,1,0,1),
            V(1,1,5'h1F,0,S1,0,0,1), V(1,1,5'h1F,0,S1,0,0,1),
            V(1,1,5'h1F,0,S1,0,0,1), V(1,1,5'h1F,0,S0,0,1,1),
            V(1,1,5'h1F,1,S1,1,0,1), V(1,0,5'h00,0,S1,0,0,1),
            V(1,0,5'h00,0,S1,0,0,1), V(1,0,5'h00,0,S1,0,0,1),
            V(1,0,5'h00,0,S1,0,1,1), V(1,0,5'h00,1,SI,0,0,0)
        };
        // Stall 4 cycles after bit 1, then idle stall.
        t_stall = '{
            V(1,1,5'h11,1,S1,1,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(0,1,5'h1F,0,SH,0,0,1), V(0,1,5'h1F,0,SH,0,0,1),
            V(0,1,5'h1F,0,SH,0,0,1), V(0,1,5'h1F,0,SH,0,0,1),
            V(1,0,5'h00,0,S0,0,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(1,0,5'h00,0,S1,0,1,1), V(1,0,5'h00,1,SI,0,0,0),
            V(0,1,5'h11,0,SH,0,0,0), V(1,0,5'h00,1,SI,0,0,0)
        };
        t_pre_rst = '{
            V(1,1,5'h11,1,S1,1,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(1,0,5'h00,0,S0,0,0,1)
        };
        t_post_rst = '{
            V(1,1,5'h01,1,S1,1,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(1,0,5'h00,0,S0,0,0,1), V(1,0,5'h00,0,S0,0,0,1),
            V(1,0,5'h00,0,S0,0,1,1), V(1,0,5'h00,1,SI,0,0,0)
        };

        rst_n    = 1'b0;
        sh_en    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();
        check_reset_outputs("after_release");

        // 32 idle cycles: filler pattern (or constant 0).
        for (int i = 0; i < 32; i++) begin
            apply(V(1,0,5'h00,1,SI,0,0,0), $sformatf("idle[%0d]", i));
`ifdef CODEWORD_TX_FILL_EN
            if (i == 0) chk("fill_first_bit", 32'(ser_out), 32'd1);
`endif
        end

        run(t_one, "one");
        chk("one.words_sent", words_sent, 32'd1);
        run(t_b2b, "b2b");
        chk("b2b.words_sent", words_sent, 32'd4);
        run(t_stall, "stall");
        chk("stall.words_sent", words_sent, 32'd5);

        // Reset mid-word at bit 2.
        run(t_pre_rst, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        in_valid = 1'b1;
        in_data  = 5'h1F;
        @(posedge clk);
        #1;
        chk("mid_rst.no_accept_busy", 32'(busy), 32'd0);
        chk("mid_rst.no_accept_ws", words_sent, 32'd0);
        release_reset();
        run(t_post_rst, "post_rst");
        chk("post_rst.words_sent", words_sent, 32'd1);

        // 100 words back-to-back; frame-aligned detection of 10001.
        hits_tx = 0;
        hits_rx = 0;
        rx      = '0;
        for (int i = 0; i < 100; i++) begin
            w = (i % 7 == 3) ? 5'h11 : W'($urandom_range(0, 31));
            if (w == 5'h11) hits_tx++;
            q = '{V(1,1,w,1,w[0] ? S1 : S0,1,0,1)};
            for (int k = 1; k < W; k++)
                q.push_back(V(1,0,5'h00,0,w[k] ? S1 : S0,0,(k == W-1),1));
            for (int k = 0; k < W; k++) begin
                apply(q[k], $sformatf("chain[%0d.%0d]", i, k));
                rx[k] = ser_out;
            end
            chk($sformatf("chain_word[%0d]", i), 32'(rx), 32'(w));
            if (rx == 5'h11) hits_rx++;
        end
        apply(V(1,0,5'h00,1,SI,0,0,0), "chain_tail");
        chk("chain.detections", hits_rx, hits_tx);
        chk("chain.words_sent", words_sent, 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
